cache_line_mem_bridge: RTL and testbench
========================================

Name: cache_line_mem_bridge

Overview:
- Sits directly downstream of the 2-way cache controller's memory-side port.
- Converts 128-bit line requests (refill read or writeback write, level-held until completion) into four sequential 32-bit word accesses on a single-port synchronous SRAM.
- Returns assembled lines with a one-cycle valid pulse, and acknowledges writebacks with a one-cycle ready pulse.

Parameters:
- MEM_ADDR_WIDTH, 10, SRAM word-address width (memory = 2^MEM_ADDR_WIDTH words).
- RD_LATENCY, 1, SRAM read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_addr  in  32  line address from controller; bits [3:0] ignored.
- req_read  in  1  line refill request, held high until rsp_rd_valid.
- req_write  in  1  line writeback request, held high until rsp_wr_ready.
- req_wr_data  in  128  writeback line; word k in bits [32k+31:32k].
- rsp_rd_data  out  128  assembled refill line.
- rsp_rd_valid  out  1  one-cycle pulse: rsp_rd_data is valid.
- rsp_wr_ready  out  1  one-cycle pulse: writeback committed.
- busy  out  1  high whenever state != IDLE.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable (only meaningful with sram_en).
- sram_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- sram_wdata  out  32  SRAM write word.
- sram_rdata  in  32  SRAM read word, valid RD_LATENCY cycles after issue.

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, latency pipeline cleared. Reset mid-operation aborts the transfer; no response pulse is generated, and sram_en=0 from the first reset cycle.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN, RESP.
- IDLE: samples requests and latches req_addr[MEM_ADDR_WIDTH+1:4] as the line base, plus req_wr_data.
  - req_write -> WR.
  - req_read -> RD_ISSUE.
  - Both high -> WR; write has priority because the writeback precedes the refill. The read is taken after RESP if still held.
- Word address = {line base, beat[1:0]}. Upper req_addr bits are ignored, so addresses wrap modulo memory size.
- WR: 4 cycles, beats 0..3. sram_en=sram_we=1, sram_wdata = word[beat]. After beat 3 -> RESP.
- RD_ISSUE: 4 cycles, beats 0..3. sram_en=1, sram_we=0.
  - Each issue pushes its beat index into an RD_LATENCY-deep valid/index delay line.
  - When a delay-line entry emerges, sram_rdata is written into rsp_rd_data[32*idx+31:32*idx].
  - After beat 3 -> RD_DRAIN.
- RD_DRAIN: waits until the beat-3 capture completes, then -> RESP.
- RESP: 1 cycle.
  - rsp_rd_valid=1 for a read; rsp_wr_ready=1 for a write.
  - -> IDLE; requests are not sampled in RESP.
  - The controller drops its request on the same edge, so IDLE does not retrigger.
- Latency, request seen in IDLE at cycle 0:
  - Write: ready pulse in cycle 5.
  - Read: valid pulse in cycle 5+RD_LATENCY (cycle 6 at default).
  - Back-to-back requests: a new request is accepted in the IDLE cycle after RESP.
- rsp_rd_data holds its value until overwritten by the next read's captures. It is meaningful only while rsp_rd_valid=1.
- Request changes outside IDLE are ignored; all transfer data comes from the latched copies.
- sram_addr and sram_wdata are 0 whenever sram_en=0.

Optional Feature:
- CACHE_LINE_MEM_BRIDGE_STATS_EN.
- Defined: adds outputs stat_rd_lines[31:0] and stat_wr_lines[31:0].
  - Each counts completed transfers, incremented in RESP.
  - Reset to 0; wrap at 2^32.
  - An aborted transfer does not count.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_mem_pkg:
  - WORD_WIDTH=32, LINE_WORDS=4, LINE_WIDTH=128, BEAT_BITS=2.
  - The state enum (IDLE, WR, RD_ISSUE, RD_DRAIN, RESP).
- Sub-module rd_latency_pipe: parameterised RD_LATENCY delay line of {valid, beat[1:0]}, with synchronous clear.
- The bench's SRAM model is a separate behavioural file, not part of the block.

Test Plan:
- Write: req_write=1, req_addr=0x0000_0120, req_wr_data=0x44444444_33333333_22222222_11111111 -> sram writes 0x11111111..0x44444444 to word addresses 0x048..0x04B on cycles 1-4; rsp_wr_ready pulses in cycle 5 only.
- Read back, RD_LATENCY=1: req_read at addr 0x120 -> rsp_rd_valid pulses in cycle 6 with rsp_rd_data=0x44444444_33333333_22222222_11111111; repeat with RD_LATENCY=3 -> pulse in cycle 8.
- Simultaneous: req_read=req_write=1 -> write of 4 beats first with ready pulse; read starts in the IDLE cycle after RESP.
- Wrap-around: MEM_ADDR_WIDTH=10, req_addr=0x0000_1FF0 -> word addresses 0x3FC..0x3FF; req_addr=0xFFFF_0FF0 hits the same words.
- Reset mid-read: rst asserted in cycle 3 of RD_ISSUE -> sram_en=0, busy=0 next cycle; no rsp_rd_valid; a new read completes correctly.
- With CACHE_LINE_MEM_BRIDGE_STATS_EN: 2 writes + 3 reads -> stat_wr_lines=2, stat_rd_lines=3; rst clears both to 0.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared widths, FSM state encoding and read-tag payload for the cache line memory bridge.
package cache_mem_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_WIDTH = 128;
    localparam int unsigned BEAT_BITS  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DRAIN,
        RESP
    } state_t;

    // Tag carried down the read-latency delay line: which beat the returning word belongs to.
    typedef struct packed {
        logic                 valid;
        logic [BEAT_BITS-1:0] beat;
    } rd_tag_t;

    // Select word `beat` of a line; word k lives in bits [32k+31:32k].
    function automatic logic [WORD_WIDTH-1:0] line_word(input logic [LINE_WIDTH-1:0] line,
                                                        input logic [BEAT_BITS-1:0]  beat);
        return line[32'(beat) * WORD_WIDTH +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/cache_line_mem_bridge_if.sv
// Line request/response channel between the cache controller (master) and the bridge (slave).
interface cache_line_mem_bridge_if;
    import cache_mem_pkg::*;

    logic [31:0]             req_addr;
    logic                    req_read;
    logic                    req_write;
    logic [LINE_WIDTH-1:0]   req_wr_data;
    logic [LINE_WIDTH-1:0]   rsp_rd_data;
    logic                    rsp_rd_valid;
    logic                    rsp_wr_ready;
    logic                    busy;

    modport master (
        output req_addr, req_read, req_write, req_wr_data,
        input  rsp_rd_data, rsp_rd_valid, rsp_wr_ready, busy
    );

    modport slave (
        input  req_addr, req_read, req_write, req_wr_data,
        output rsp_rd_data, rsp_rd_valid, rsp_wr_ready, busy
    );

endinterface

// File: rtl/rd_latency_pipe.sv
// RD_LATENCY-deep delay line of read tags; the tag emerges in the cycle its SRAM word is valid.
module rd_latency_pipe
    import cache_mem_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t in_tag,
    output rd_tag_t out_tag
);

    for (genvar g = 0; g < int'(RD_LATENCY); g++) begin : g_stage
        rd_tag_t q;
        if (g == 0) begin : g_first
            // First stage captures the tag of the read issued this cycle.
            always_ff @(posedge clk) begin
                if (clr) q <= '0;
                else     q <= in_tag;
            end
        end else begin : g_next
            // Later stages shift the tag one cycle further.
            always_ff @(posedge clk) begin
                if (clr) q <= '0;
                else     q <= g_stage[g-1].q;
            end
        end
    end

    assign out_tag = g_stage[RD_LATENCY-1].q;

endmodule

// File: rtl/cache_line_mem_bridge.sv
// Cache line <-> 32-bit SRAM bridge: splits each 128-bit refill/writeback into four word accesses.
// Optional build macro CACHE_LINE_MEM_BRIDGE_STATS_EN adds completed-line counters.
module cache_line_mem_bridge
    import cache_mem_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    cache_line_mem_bridge_if.slave    bus,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0]     sram_wdata,
    input  logic [WORD_WIDTH-1:0]     sram_rdata
`ifdef CACHE_LINE_MEM_BRIDGE_STATS_EN
    ,
    output logic [31:0]               stat_rd_lines,
    output logic [31:0]               stat_wr_lines
`endif
);

    localparam int unsigned BASE_WIDTH = MEM_ADDR_WIDTH - BEAT_BITS;

    state_t                    state, state_d;
    logic [BEAT_BITS-1:0]      beat, beat_d;
    logic [BASE_WIDTH-1:0]     base, base_d;
    logic [LINE_WIDTH-1:0]     line, line_d;
    logic                      op_rd, op_rd_d;

    logic                      sram_en_d, sram_we_d;
    logic [MEM_ADDR_WIDTH-1:0] sram_addr_d;
    logic [WORD_WIDTH-1:0]     sram_wdata_d;
    logic                      busy_d, busy_q;
    logic                      rd_valid_d, rd_valid_q;
    logic                      wr_ready_d, wr_ready_q;
    logic [LINE_WIDTH-1:0]     rd_line;

    rd_tag_t                   push_tag, pop_tag;

    // Only the line-index bits of the request address select SRAM words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:MEM_ADDR_WIDTH+2], bus.req_addr[3:0]};

    // Every read issue enters the delay line tagged with its beat.
    assign push_tag.valid = (state == RD_ISSUE);
    assign push_tag.beat  = beat;

    rd_latency_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .clr     (rst),
        .in_tag  (push_tag),
        .out_tag (pop_tag)
    );

    // Next state plus next values of the registered outputs (computed from the next state).
    always_comb begin
        state_d = state;
        beat_d  = beat;
        base_d  = base;
        line_d  = line;
        op_rd_d = op_rd;

        case (state)
            IDLE: begin
                if (bus.req_write || bus.req_read) begin
                    base_d  = bus.req_addr[MEM_ADDR_WIDTH+1:4];
                    line_d  = bus.req_wr_data;
                    beat_d  = '0;
                    op_rd_d = !bus.req_write;
                    state_d = bus.req_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                beat_d = beat + BEAT_BITS'(1);
                if (beat == BEAT_BITS'(LINE_WORDS - 1)) state_d = RESP;
            end
            RD_ISSUE: begin
                beat_d = beat + BEAT_BITS'(1);
                if (beat == BEAT_BITS'(LINE_WORDS - 1)) state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (pop_tag.valid && pop_tag.beat == BEAT_BITS'(LINE_WORDS - 1)) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sram_en_d    = (state_d == WR) || (state_d == RD_ISSUE);
        sram_we_d    = (state_d == WR);
        sram_addr_d  = sram_en_d ? {base_d, beat_d} : '0;
        sram_wdata_d = sram_we_d ? line_word(line_d, beat_d) : '0;
        busy_d       = (state_d != IDLE);
        rd_valid_d   = (state_d == RESP) && op_rd_d;
        wr_ready_d   = (state_d == RESP) && !op_rd_d;
    end

    // State, latched request and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            line       <= '0;
            op_rd      <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state      <= state_d;
            beat       <= beat_d;
            base       <= base_d;
            line       <= line_d;
            op_rd      <= op_rd_d;
            sram_en    <= sram_en_d;
            sram_we    <= sram_we_d;
            sram_addr  <= sram_addr_d;
            sram_wdata <= sram_wdata_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Drop each returning SRAM word into its slot of the refill line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_line <= '0;
        end else if (pop_tag.valid) begin
            rd_line[32'(pop_tag.beat) * WORD_WIDTH +: WORD_WIDTH] <= sram_rdata;
        end
    end

    assign bus.rsp_rd_data  = rd_line;
    assign bus.rsp_rd_valid = rd_valid_q;
    assign bus.rsp_wr_ready = wr_ready_q;
    assign bus.busy         = busy_q;

`ifdef CACHE_LINE_MEM_BRIDGE_STATS_EN
    // Count lines whose transfer reached the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_lines <= '0;
            stat_wr_lines <= '0;
        end else if (state == RESP) begin
            if (op_rd) stat_rd_lines <= stat_rd_lines + 32'd1;
            else       stat_wr_lines <= stat_wr_lines + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_mem_bridge.sv
// Bench for cache_line_mem_bridge: two instances (RD_LATENCY 1 and 3), each with a behavioural
// SRAM, checked against a word-array reference model. Honours CACHE_LINE_MEM_BRIDGE_STATS_EN.
module tb_cache_line_mem_bridge;

    localparam int unsigned NL        = 2;
    localparam int unsigned AW        = 10;
    localparam int unsigned MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    logic [31:0]    req_addr     [NL];
    logic           req_read     [NL];
    logic           req_write    [NL];
    logic [127:0]   req_wr_data  [NL];
    logic [127:0]   rsp_rd_data  [NL];
    logic           rsp_rd_valid [NL];
    logic           rsp_wr_ready [NL];
    logic           busy         [NL];
    logic           sram_en      [NL];
    logic           sram_we      [NL];
    logic [AW-1:0]  sram_addr    [NL];
    logic [31:0]    sram_wdata   [NL];
    logic [31:0]    sram_rdata   [NL];
    logic [31:0]    stat_rd      [NL];
    logic [31:0]    stat_wr      [NL];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [NL][MEM_WORDS];
    int unsigned exp_rd_cnt [NL];
    int unsigned exp_wr_cnt [NL];

    function automatic logic [31:0] init_word(input int l, input int unsigned i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'(l);
    endfunction

    function automatic int unsigned lat(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    // Word address of beat k of the line holding byte address a, wrapped to memory size.
    function automatic logic [AW-1:0] waddr(input logic [31:0] a, input int unsigned k);
        int unsigned w;
        w = ((int'(a) >>> 0) == 0) ? 0 : 0;
        w = ((a / 32'd16) * 32'd4 + k) % MEM_WORDS;
        return AW'(w);
    endfunction

    for (genvar g = 0; g < int'(NL); g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        cache_line_mem_bridge_if bus ();

        assign bus.req_addr     = req_addr[g];
        assign bus.req_read     = req_read[g];
        assign bus.req_write    = req_write[g];
        assign bus.req_wr_data  = req_wr_data[g];
        assign rsp_rd_data[g]   = bus.rsp_rd_data;
        assign rsp_rd_valid[g]  = bus.rsp_rd_valid;
        assign rsp_wr_ready[g]  = bus.rsp_wr_ready;
        assign busy[g]          = bus.busy;

        cache_line_mem_bridge #(
            .MEM_ADDR_WIDTH (AW),
            .RD_LATENCY     (LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .sram_en    (sram_en[g]),
            .sram_we    (sram_we[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_rdata (sram_rdata[g])
`ifdef CACHE_LINE_MEM_BRIDGE_STATS_EN
            ,
            .stat_rd_lines (stat_rd[g]),
            .stat_wr_lines (stat_wr[g])
`endif
        );

`ifndef CACHE_LINE_MEM_BRIDGE_STATS_EN
        assign stat_rd[g] = '0;
        assign stat_wr[g] = '0;
`endif

        // Behavioural single-port SRAM with LAT-cycle read latency; idle read data is poisoned.
        logic [31:0] mem [MEM_WORDS];
        logic [31:0] rq  [LAT];
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_word(g, i);
            end else if (sram_en[g] && sram_we[g]) begin
                mem[sram_addr[g]] <= sram_wdata[g];
            end
            rq[0] <= (sram_en[g] && !sram_we[g]) ? mem[sram_addr[g]] : 32'hDEAD_BEEF;
            for (int i = 1; i < int'(LAT); i++) rq[i] <= rq[i-1];
        end
        assign sram_rdata[g] = rq[LAT-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int l, input string tag);
        chk($sformatf("%s idle lane%0d", tag, l),
            {busy[l], rsp_rd_valid[l], rsp_wr_ready[l], sram_en[l], sram_we[l], sram_addr[l], sram_wdata[l]},
            '0);
    endtask

    // One line transfer from IDLE: checks each SRAM beat, pulse latency, read data and return to idle.
    task automatic run_txn(input int l, input bit is_wr, input logic [31:0] addr, input logic [127:0] wdata);
        logic [127:0] exp_line;
        int unsigned  exp_lat;
        int           got;
        bit           seen;
        bit           other;
        for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = ref_mem[l][waddr(addr, k)];
        exp_lat        = is_wr ? 5 : 5 + lat(l);
        req_addr[l]    = addr;
        req_wr_data[l] = wdata;
        req_write[l]   = is_wr;
        req_read[l]    = !is_wr;
        seen  = 1'b0;
        other = 1'b0;
        got   = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            tick();
            if (c <= 4) begin
                chk($sformatf("beat%0d en lane%0d", c-1, l), sram_en[l], 1'b1);
                chk($sformatf("beat%0d we lane%0d", c-1, l), sram_we[l], is_wr);
                chk($sformatf("beat%0d addr lane%0d", c-1, l), sram_addr[l], waddr(addr, c-1));
                if (is_wr) chk($sformatf("beat%0d wdata lane%0d", c-1, l), sram_wdata[l], wdata[32*(c-1) +: 32]);
            end
            if (is_wr ? rsp_rd_valid[l] : rsp_wr_ready[l]) other = 1'b1;
            if (is_wr ? rsp_wr_ready[l] : rsp_rd_valid[l]) begin
                seen         = 1'b1;
                got          = c;
                req_read[l]  = 1'b0;
                req_write[l] = 1'b0;
                if (!is_wr) chk($sformatf("rdata lane%0d addr %h", l, addr), rsp_rd_data[l], exp_line);
            end
        end
        req_read[l]  = 1'b0;
        req_write[l] = 1'b0;
        chk($sformatf("%s latency lane%0d", is_wr ? "wr" : "rd", l), 128'(got), 128'(exp_lat));
        chk($sformatf("wrong pulse lane%0d", l), other, 1'b0);
        tick();
        chk_idle(l, "post");
        if (is_wr) begin
            for (int k = 0; k < 4; k++) ref_mem[l][waddr(addr, k)] = wdata[32*k +: 32];
            exp_wr_cnt[l]++;
        end else begin
            exp_rd_cnt[l]++;
        end
    endtask

    // Read and write requested together: write completes first, read follows after RESP.
    task automatic both_txn(input int l, input logic [31:0] addr, input logic [127:0] wdata);
        int wr_c;
        int rd_c;
        req_addr[l]    = addr;
        req_wr_data[l] = wdata;
        req_write[l]   = 1'b1;
        req_read[l]    = 1'b1;
        wr_c = 0;
        rd_c = 0;
        for (int c = 1; c <= 40 && rd_c == 0; c++) begin
            tick();
            if (c <= 4) chk($sformatf("both beat%0d we lane%0d", c-1, l), sram_we[l], 1'b1);
            if (c == 6) chk($sformatf("both gap busy lane%0d", l), busy[l], 1'b0);
            if (rsp_wr_ready[l] && wr_c == 0) begin
                wr_c         = c;
                req_write[l] = 1'b0;
                for (int k = 0; k < 4; k++) ref_mem[l][waddr(addr, k)] = wdata[32*k +: 32];
                exp_wr_cnt[l]++;
            end
            if (rsp_rd_valid[l]) begin
                rd_c        = c;
                req_read[l] = 1'b0;
                chk($sformatf("both rdata lane%0d", l), rsp_rd_data[l], wdata);
                exp_rd_cnt[l]++;
            end
        end
        req_write[l] = 1'b0;
        req_read[l]  = 1'b0;
        chk($sformatf("both wr latency lane%0d", l), 128'(wr_c), 128'd5);
        chk($sformatf("both rd latency lane%0d", l), 128'(rd_c), 128'(11 + lat(l)));
        tick();
        chk_idle(l, "both");
    endtask

    // Reset during the third issue cycle of a read must abort it without a response.
    task automatic reset_mid_read(input int l, input logic [31:0] addr);
        bit saw;
        req_addr[l] = addr;
        req_read[l] = 1'b1;
        tick();
        tick();
        tick();
        chk($sformatf("pre-reset en lane%0d", l), sram_en[l], 1'b1);
        rst         = 1'b1;
        req_read[l] = 1'b0;
        tick();
        chk($sformatf("reset en lane%0d", l), sram_en[l], 1'b0);
        chk($sformatf("reset busy lane%0d", l), busy[l], 1'b0);
        chk($sformatf("reset rdata lane%0d", l), rsp_rd_data[l], '0);
        rst = 1'b0;
        for (int i = 0; i < int'(NL); i++) begin
            exp_rd_cnt[i] = 0;
            exp_wr_cnt[i] = 0;
        end
        saw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rsp_rd_valid[l] || busy[l]) saw = 1'b1;
        end
        chk($sformatf("aborted read silent lane%0d", l), saw, 1'b0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef CACHE_LINE_MEM_BRIDGE_STATS_EN
        for (int l = 0; l < int'(NL); l++) begin
            chk($sformatf("%s stat_rd lane%0d", tag, l), stat_rd[l], exp_rd_cnt[l]);
            chk($sformatf("%s stat_wr lane%0d", tag, l), stat_wr[l], exp_wr_cnt[l]);
        end
`else
        if (tag.len() == 0) tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  a;
        logic [127:0] d;
        rst      = 1'b1;
        mem_init = 1'b1;
        for (int l = 0; l < int'(NL); l++) begin
            req_addr[l]    = '0;
            req_read[l]    = 1'b0;
            req_write[l]   = 1'b0;
            req_wr_data[l] = '0;
            exp_rd_cnt[l]  = 0;
            exp_wr_cnt[l]  = 0;
            for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[l][i] = init_word(l, i);
        end
        tick();
        tick();
        tick();
        mem_init = 1'b0;
        for (int l = 0; l < int'(NL); l++) begin
            chk_idle(l, "reset");
            chk($sformatf("reset rdata lane%0d", l), rsp_rd_data[l], '0);
        end
        chk_stats("reset");
        rst = 1'b0;
        tick();

        // Directed write then read-back of the same line on both latencies.
        for (int l = 0; l < int'(NL); l++) begin
            run_txn(l, 1'b1, 32'h0000_0120, 128'h44444444_33333333_22222222_11111111);
            run_txn(l, 1'b0, 32'h0000_0120, '0);
        end

        // Top line of memory, reached through an aliased high address.
        for (int l = 0; l < int'(NL); l++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_txn(l, 1'b1, 32'h0000_1FF0, d);
            run_txn(l, 1'b0, 32'hFFFF_0FF0, '0);
        end

        // Simultaneous read and write requests.
        for (int l = 0; l < int'(NL); l++) begin
            both_txn(l, 32'h0000_0340, {$urandom, $urandom, $urandom, $urandom});
        end

        // Random traffic over a small set of lines with random alias bits.
        for (int i = 0; i < 32; i++) begin
            int l;
            l = int'($urandom_range(0, NL - 1));
            a = ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 15)) << 4);
            d = {$urandom, $urandom, $urandom, $urandom};
            run_txn(l, 1'($urandom_range(0, 1)), a, d);
        end
        chk_stats("random");

        // Abort a read with reset, then confirm a fresh read still works.
        for (int l = 0; l < int'(NL); l++) begin
            reset_mid_read(l, 32'h0000_0120);
            chk_stats("after reset");
            run_txn(l, 1'b0, 32'h0000_0120, '0);
        end
        run_txn(0, 1'b1, 32'h0000_0200, {$urandom, $urandom, $urandom, $urandom});
        chk_stats("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
